// File: rtl/tilemap_update_ctrl.sv
// tilemap_update_ctrl
//   Owns the dot and big-dot bitmaps read by the map renderer. Eat requests
//   from player movement and level refills from the game FSM are committed
//   only while vblank=1, so the renderer never sees a mid-frame map change.
//   Also tracks the number of remaining dots and the level-clear flag.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   vblank              display is in vertical blanking
//   eat_req/eat_idx     clear-tile request (held until eat_ack) and tile index
//   eat_ack             one-cycle acknowledge of a committed eat
//   refill_req          one-cycle pulse: load dots_init/big_init
//   dots_init/big_init  level patterns, stable while refill_busy
//   refill_busy         refill pending or in progress
//   tilemap_dots/_big_dots  current bitmaps
//   dots_left           set bits in (dots | big_dots)
//   dot_eaten/big_eaten one-cycle pulses in the ACK cycle
//   level_clear         level loaded and no dots left
module tilemap_update_ctrl #(
    parameter int TILE_COLS = 32,
    parameter int TILE_ROWS = 24,
    parameter int N_TILES   = TILE_COLS * TILE_ROWS,
    parameter int IDX_W     = 10,
    parameter int CNT_W     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vblank,
    input  logic               eat_req,
    input  logic [IDX_W-1:0]   eat_idx,
    output logic               eat_ack,
    input  logic               refill_req,
    input  logic [N_TILES-1:0] dots_init,
    input  logic [N_TILES-1:0] big_init,
    output logic               refill_busy,
    output logic [N_TILES-1:0] tilemap_dots,
    output logic [N_TILES-1:0] tilemap_big_dots,
    output logic [CNT_W-1:0]   dots_left,
    output logic               dot_eaten,
    output logic               big_eaten,
    output logic               level_clear
);

    typedef enum logic [2:0] {
        S_IDLE, S_EAT_WAIT, S_EAT_COMMIT, S_ACK, S_REFILL_WAIT, S_REFILL, S_COUNT
    } state_t;

    state_t             state, state_nxt;
    logic               refill_pend, pend_nxt, pend_eff;
    logic               loaded, loaded_nxt;
    logic [IDX_W-1:0]   scan_idx, idx_nxt;
    logic [N_TILES-1:0] dots_nxt, big_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ack_nxt, dot_nxt, bige_nxt, busy_nxt, clear_nxt;
    logic               in_range, refill_phase_nxt;

    assign in_range = (32'(eat_idx) < 32'(N_TILES));

    always_comb begin
        state_nxt = state;
        dots_nxt  = tilemap_dots;
        big_nxt   = tilemap_big_dots;
        cnt_nxt   = dots_left;
        idx_nxt   = scan_idx;
        loaded_nxt = loaded;
        dot_nxt   = 1'b0;
        bige_nxt  = 1'b0;
        // A refill pulse arriving this cycle is acted on immediately so that
        // refill gets priority over an eat raised in the same cycle.
        pend_eff  = refill_pend | refill_req;

        case (state)
            S_IDLE: begin
                if (pend_eff)     state_nxt = S_REFILL_WAIT;
                else if (eat_req) state_nxt = S_EAT_WAIT;
            end
            S_EAT_WAIT: begin
                // Eat stays unacked; it is picked up again from IDLE after COUNT.
                if (pend_eff)    state_nxt = S_REFILL_WAIT;
                else if (vblank) state_nxt = S_EAT_COMMIT;
            end
            S_EAT_COMMIT: begin
                if (in_range) begin
                    if (tilemap_dots[eat_idx]) begin
                        dots_nxt[eat_idx] = 1'b0;
                        big_nxt[eat_idx]  = 1'b0;
                        cnt_nxt  = dots_left - CNT_W'(1);
                        dot_nxt  = 1'b1;
                    end else if (tilemap_big_dots[eat_idx]) begin
                        big_nxt[eat_idx] = 1'b0;
                        cnt_nxt  = dots_left - CNT_W'(1);
                        bige_nxt = 1'b1;
                    end
                end
                state_nxt = S_ACK;
            end
            S_ACK: state_nxt = S_IDLE;
            S_REFILL_WAIT: begin
                if (vblank) state_nxt = S_REFILL;
            end
            S_REFILL: begin
                dots_nxt  = dots_init;
                big_nxt   = big_init;
                cnt_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = S_COUNT;
            end
            S_COUNT: begin
                cnt_nxt = dots_left + CNT_W'(tilemap_dots[scan_idx] | tilemap_big_dots[scan_idx]);
                if (scan_idx == IDX_W'(N_TILES - 1)) begin
                    loaded_nxt = 1'b1;
                    state_nxt  = S_IDLE;
                end else begin
                    idx_nxt = scan_idx + IDX_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        refill_phase_nxt = (state_nxt == S_REFILL_WAIT) || (state_nxt == S_REFILL) ||
                           (state_nxt == S_COUNT);
        pend_nxt  = pend_eff & (state_nxt != S_REFILL);
        ack_nxt   = (state_nxt == S_ACK);
        busy_nxt  = pend_nxt | refill_phase_nxt;
        clear_nxt = loaded_nxt & (cnt_nxt == '0) & ~refill_phase_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            refill_pend      <= 1'b0;
            loaded           <= 1'b0;
            scan_idx         <= '0;
            tilemap_dots     <= '0;
            tilemap_big_dots <= '0;
            dots_left        <= '0;
            eat_ack          <= 1'b0;
            dot_eaten        <= 1'b0;
            big_eaten        <= 1'b0;
            refill_busy      <= 1'b0;
            level_clear      <= 1'b0;
        end else begin
            state            <= state_nxt;
            refill_pend      <= pend_nxt;
            loaded           <= loaded_nxt;
            scan_idx         <= idx_nxt;
            tilemap_dots     <= dots_nxt;
            tilemap_big_dots <= big_nxt;
            dots_left        <= cnt_nxt;
            eat_ack          <= ack_nxt;
            dot_eaten        <= dot_nxt;
            big_eaten        <= bige_nxt;
            refill_busy      <= busy_nxt;
            level_clear      <= clear_nxt;
        end
    end

endmodule
